load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//  Sits between the execute stage and the 64-bit word-addressed data memory_unit. Accepts
//  one load/store per handshake, converts the byte address to a word address, extracts and
//  sign/zero-extends load data, and implements sub-word stores as read-modify-write,
//  because the memory has no byte enables. Misaligned accesses raise a fault with no memory access.
// PARAMETERS
//  XLEN         64  request address/data width (bits)
//  MEM_ADDRSIZE 16  memory word-address width; word addr = req_addr[MEM_ADDRSIZE+2:3]
// PORTS
//  clk         in   1             clock, rising edge
//  rst         in   1             reset: asynchronous, active-high
//  req_valid   in   1             request present
//  req_ready   out  1             LSU can accept (high only in IDLE)
//  req_store   in   1             1=store, 0=load
//  req_funct3  in   3             RV size/sign: 000 B,001 H,010 W,011 D,100 BU,101 HU,110 WU
//  req_addr    in   XLEN          byte address
//  req_wdata   in   XLEN          store data (low bytes used for sub-word stores)
//  resp_valid  out  1             response present, held until resp_ready
//  resp_ready  in   1             consumer takes response
//  resp_rdata  out  XLEN          extended load data (0 for stores/faults)
//  resp_fault  out  1             misaligned address or illegal funct3 (111, or store with funct3[2]=1)
//  mem_wren    out  1             memory write enable
//  mem_rden    out  1             memory read enable
//  mem_addr    out  MEM_ADDRSIZE  memory word address
//  mem_d       out  64            memory write data
//  mem_q       in   64            memory read data (combinational, valid while mem_rden high)
// BEHAVIOUR
//  Reset: state IDLE; resp_valid, resp_fault, mem_wren, mem_rden = 0; resp_rdata, mem_addr, mem_d = 0.
//  All mem_* and resp_* outputs come from flops; req_ready = (state==IDLE).
//  Request is accepted on a clock edge with req_valid & req_ready; addr, funct3 and wdata are latched.
//  Alignment: H needs addr[0]=0, W needs addr[1:0]=0, D needs addr[2:0]=0; byte offset off = addr[2:0].
//  FSM:
//   IDLE  --accept, fault---------> RESP (fault=1, no mem access; 1 cycle to resp_valid)
//   IDLE  --accept, load----------> READ
//   IDLE  --accept, store D-------> WRITE (mem_d = wdata)
//   IDLE  --accept, store B/H/W---> READ
//   READ : mem_rden=1 for exactly 1 cycle; mem_q is captured at the end of the cycle.
//          Load -> RESP with extracted lane (mem_q >> 8*off), sign- or zero-extended by funct3.
//          Store -> WRITE with merged = mem_q with bytes [off +: size] replaced by wdata low bytes.
//   WRITE: mem_wren=1 for exactly 1 cycle; mem_addr and mem_d are stable for the whole cycle -> RESP.
//   RESP : resp_valid=1; leave to IDLE on resp_ready. No new request is accepted in RESP.
//  Latency, accept edge to resp_valid: load 2 cycles, store D 2, sub-word store 3, fault 1.
//  mem_wren and mem_rden are never both high; both are low outside READ/WRITE.
//  mem_addr holds its value from accept until the next accept, so no glitches reach the memory.
//  Back-to-back: with resp_ready held high, the next request is accepted on the cycle after RESP.
//  rst mid-operation: the FSM is forced to IDLE asynchronously and mem_wren drops at once;
//   a half-done RMW leaves memory unmodified, and the pending response is discarded.
//  Address bits above MEM_ADDRSIZE+2 are ignored; the address wraps modulo the memory size.
// STRUCTURE
//  Shared package riscv_pkg: funct3 load/store encodings (LS_B..LS_WU), the size-decode function,
//   and FSM state constants (S_IDLE, S_READ, S_WRITE, S_RESP), 2-bit encoding.
//  Sub-module lsu_lane_align (combinational): given word, off and funct3, produces
//   load_ext (extracted and extended) and store_merge (RMW word).
//   The FSM, handshake and output flops stay in load_store_unit.
// TESTING
//  1 SD 0x1122334455667788 @0x10, then LD @0x10 -> one wren cycle, mem_addr=2; rdata=0x1122334455667788.
//  2 word=0x80FF..., LB @off7 -> 0xFFFF_FFFF_FFFF_FF80; LBU -> 0x80; LH @6 -> 0xFFFF_FFFF_FFFF_80FF.
//  3 word=0x0, SB 0xAB @0x13 -> READ then WRITE, mem_d=0x0000_0000_AB00_0000; total 3 cycles to resp_valid.
//  4 LW @0x102, SD @0x104, funct3=111 -> resp_fault=1 after 1 cycle, mem_rden=mem_wren=0 throughout.
//  5 resp_ready low for 5 cycles -> resp_valid/rdata stable, req_ready=0; next accept after release.
//  6 assert rst during the WRITE cycle of a SH -> mem_wren drops asynchronously, memory unchanged, IDLE, req_ready=1.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared load/store encodings, FSM state constants and size helpers for the LSU.
package riscv_pkg;

  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_D  = 3'b011;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;
  localparam logic [2:0] LS_WU = 3'b110;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  // Byte mask of the access size, aligned to lane 0.
  function automatic logic [63:0] size_mask(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   size_mask = 64'h0000_0000_0000_00FF;
      2'b01:   size_mask = 64'h0000_0000_0000_FFFF;
      2'b10:   size_mask = 64'h0000_0000_FFFF_FFFF;
      default: size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] funct3, input logic [2:0] off);
    case (funct3[1:0])
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = off[0];
      2'b10:   misaligned = |off[1:0];
      default: misaligned = |off;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: load extraction with sign/zero extension and
// the read-modify-write merge for sub-word stores.
module lsu_lane_align
  import riscv_pkg::*;
(
  input  logic [63:0] word,
  input  logic [2:0]  off,
  input  logic [2:0]  funct3,
  input  logic [63:0] wdata,
  output logic [63:0] load_ext,
  output logic [63:0] store_merge
);

  logic [5:0]  shamt;
  logic [63:0] lane;
  logic [63:0] mask;

  assign shamt = {off, 3'b000};
  assign lane  = word >> shamt;
  assign mask  = size_mask(funct3) << shamt;

  always_comb begin
    load_ext = lane;
    case (funct3)
      LS_B:    load_ext = {{56{lane[7]}}, lane[7:0]};
      LS_H:    load_ext = {{48{lane[15]}}, lane[15:0]};
      LS_W:    load_ext = {{32{lane[31]}}, lane[31:0]};
      LS_BU:   load_ext = {56'd0, lane[7:0]};
      LS_HU:   load_ext = {48'd0, lane[15:0]};
      LS_WU:   load_ext = {32'd0, lane[31:0]};
      default: load_ext = lane;
    endcase
  end

  assign store_merge = (word & ~mask) | ((wdata << shamt) & mask);

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit in front of a 64-bit word memory without byte enables:
// sub-word stores are read-modify-write, misaligned/illegal requests fault.
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int XLEN         = 64,
  parameter int MEM_ADDRSIZE = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_store,
  input  logic [2:0]              req_funct3,
  input  logic [XLEN-1:0]         req_addr,
  input  logic [XLEN-1:0]         req_wdata,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [XLEN-1:0]         resp_rdata,
  output logic                    resp_fault,
  output logic                    mem_wren,
  output logic                    mem_rden,
  output logic [MEM_ADDRSIZE-1:0] mem_addr,
  output logic [63:0]             mem_d,
  input  logic [63:0]             mem_q,
  output logic [1:0]              dbg_state
);

  // Handshakes: a request transfers on a rising edge with req_valid & req_ready;
  // a response transfers on a rising edge with resp_valid & resp_ready, and
  // resp_valid/resp_rdata/resp_fault hold steady until then.

  logic [1:0]              state, next_state;
  logic [2:0]              off_q, funct3_q;
  logic [XLEN-1:0]         wdata_q;
  logic                    store_q;
  logic                    accept, req_fault;
  logic [63:0]             load_ext, store_merge;
  logic                    mem_rden_nxt, mem_wren_nxt, resp_valid_nxt, resp_fault_nxt;
  logic [63:0]             mem_d_nxt;
  logic [XLEN-1:0]         resp_rdata_nxt;
  logic [MEM_ADDRSIZE-1:0] mem_addr_nxt;
  logic                    unused_addr_hi;

  assign unused_addr_hi = ^req_addr[XLEN-1:MEM_ADDRSIZE+3];

  assign req_ready = (state == S_IDLE);
  assign dbg_state = state;
  assign accept    = req_valid & req_ready;
  assign req_fault = (req_funct3 == 3'b111) | (req_store & req_funct3[2])
                   | misaligned(req_funct3, req_addr[2:0]);

  lsu_lane_align u_align (
    .word        (mem_q),
    .off         (off_q),
    .funct3      (funct3_q),
    .wdata       (wdata_q[63:0]),
    .load_ext    (load_ext),
    .store_merge (store_merge)
  );

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          if (req_fault)                               next_state = S_RESP;
          else if (req_store && req_funct3[1:0] == 2'b11) next_state = S_WRITE;
          else                                         next_state = S_READ;
        end
      end
      S_READ:  next_state = store_q ? S_WRITE : S_RESP;
      S_WRITE: next_state = S_RESP;
      S_RESP:  if (resp_ready) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Every memory/response output is the registered image of the next state.
  always_comb begin
    mem_rden_nxt   = (next_state == S_READ);
    mem_wren_nxt   = (next_state == S_WRITE);
    resp_valid_nxt = (next_state == S_RESP);
    mem_addr_nxt   = accept ? req_addr[MEM_ADDRSIZE+2:3] : mem_addr;
    mem_d_nxt      = mem_d;
    resp_rdata_nxt = resp_rdata;
    resp_fault_nxt = resp_fault;
    if (next_state == S_WRITE) begin
      mem_d_nxt = (state == S_READ) ? store_merge : req_wdata[63:0];
    end
    if (next_state == S_RESP && state != S_RESP) begin
      resp_fault_nxt = (state == S_IDLE);
      resp_rdata_nxt = (state == S_READ && !store_q) ? load_ext : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      off_q      <= '0;
      funct3_q   <= '0;
      wdata_q    <= '0;
      store_q    <= 1'b0;
      mem_rden   <= 1'b0;
      mem_wren   <= 1'b0;
      mem_addr   <= '0;
      mem_d      <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_fault <= 1'b0;
    end else begin
      state      <= next_state;
      if (accept) begin
        off_q    <= req_addr[2:0];
        funct3_q <= req_funct3;
        wdata_q  <= req_wdata;
        store_q  <= req_store;
      end
      mem_rden   <= mem_rden_nxt;
      mem_wren   <= mem_wren_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_d      <= mem_d_nxt;
      resp_valid <= resp_valid_nxt;
      resp_rdata <= resp_rdata_nxt;
      resp_fault <= resp_fault_nxt;
    end
  end

endmodule
